// File: rtl/ysyx_23060025_lsu_axi_master.sv
// Single-outstanding AXI4-Lite master: one core load/store port onto AR/R/AW/W/B,
// with write lane alignment and read-data realignment by addr[1:0].
//  state  | meaning
//  IDLE   | ready for a core request; response pulse is also issued here
//  AR     | read address presented, waiting for arready
//  R      | waiting for read data beat
//  AW_W   | write address and data presented independently until both accepted
//  B      | waiting for write response
module ysyx_23060025_lsu_axi_master #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic [DATA_LEN-1:0] req_wdata_i,
    input  logic [3:0]          req_wmask_i,
    output logic                rsp_valid_o,
    output logic [DATA_LEN-1:0] rsp_rdata_o,
    output logic                rsp_err_o,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    input  logic                rlast_i,
    output logic                rready_o,
    output logic [ADDR_LEN-1:0] awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [3:0]          wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [3:0]          wstrb_q;
    logic                aw_done;
    logic                w_done;

    logic                accept;
    logic                ar_hs;
    logic                r_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic [4:0]          shamt_req;
    logic [4:0]          shamt_q;
    logic [3:0]          wstrb_req;
    logic                unused_ok;

    assign accept    = req_valid_i & req_ready_o;
    assign ar_hs     = arvalid_o & arready_i;
    assign r_hs      = rready_o & rvalid_i;
    assign aw_hs     = awvalid_o & awready_i;
    assign w_hs      = wvalid_o & wready_i;
    assign b_hs      = bready_o & bvalid_i;
    assign shamt_req = {req_addr_i[1:0], 3'b000};
    assign shamt_q   = {addr_q[1:0], 3'b000};
    // Strobe bits shifted past lane 3 are dropped by the 4-bit result width.
    assign wstrb_req = req_wmask_i << req_addr_i[1:0];
    assign unused_ok = &{1'b0, rlast_i};

    assign araddr_o = addr_q;
    assign awaddr_o = addr_q;
    assign wdata_o  = wdata_q;
    assign wstrb_o  = wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = req_wen_i ? S_AW_W : S_AR;
            S_AR:   if (ar_hs) state_nxt = S_R;
            S_R:    if (r_hs) state_nxt = S_IDLE;
            S_AW_W: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = S_B;
            S_B:    if (b_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        awvalid_o   = 1'b0;
        wvalid_o    = 1'b0;
        bready_o    = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: req_ready_o = 1'b1;
                S_AR:   arvalid_o   = 1'b1;
                S_R:    rready_o    = 1'b1;
                S_AW_W: begin
                    awvalid_o = ~aw_done;
                    wvalid_o  = ~w_done;
                end
                S_B:    bready_o    = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i << shamt_req;
                wstrb_q <= wstrb_req;
            end
            // Done flags only live while both channels are still being negotiated.
            if (state == S_AW_W && state_nxt == S_AW_W) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            rsp_valid_o <= r_hs | b_hs;
            if (r_hs) begin
                rsp_rdata_o <= rdata_i >> shamt_q;
                rsp_err_o   <= |rresp_i;
            end else if (b_hs) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= |bresp_i;
            end
        end
    end

endmodule
